kernel_accumulator: RTL and testbench
=====================================

# kernel_accumulator

Sequential reduction stage of the convolver datapath. It sits directly downstream of the element-wise product stage. It accepts one packed bus of KERNEL_SIZE² products per transaction and sums them serially, one element per clock, into a single DATA_WIDTH result. The result is presented on a valid/ready output handshake.

## Interface

Parameters
- DATA_WIDTH, 32, width of each product element and of the result.
- KERNEL_SIZE, 3, kernel edge length; the input carries N = KERNEL_SIZE² elements (N ≥ 1).

Ports
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- products_in  input  N*DATA_WIDTH  packed products; element i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- in_valid  input  1  products_in is valid.
- in_ready  output  1  block can accept a new product set.
- sum_out  output  DATA_WIDTH  reduced sum.
- out_valid  output  1  sum_out is valid.
- out_ready  input  1  downstream accepts sum_out.
- busy  output  1  high whenever state ≠ IDLE.

## Operation

- The FSM has three states: IDLE, ACCUM and DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture products_in into an internal N-element register, clear the accumulator, set index=0, go to ACCUM.
- **ACCUM**
  - in_ready=0; in_valid and products_in are ignored.
  - Each cycle: acc ← acc + elem[index], index ← index+1.
  - Summation order is element 0 first, ascending.
  - On the cycle that adds elem[N-1]: load sum_out with the final sum and go to DONE.
- **DONE**
  - out_valid=1; sum_out is held stable.
  - On out_ready: go to IDLE. out_valid drops after that edge.
  - While out_ready=0, stay in DONE indefinitely with sum_out unchanged.
- **Arithmetic**
  - Unsigned, modulo 2^DATA_WIDTH. Overflow wraps silently; no carry or saturation output.
  - The index counter is ceil(log2(N+1)) bits wide and never wraps within a transaction.
- **Reset**
  - rst_n low at any time, including mid-ACCUM or in DONE, immediately forces state=IDLE, acc=0, index=0, sum_out=0, out_valid=0, busy=0.
  - Captured products are discarded.
  - in_ready rises to 1 combinationally from state while reset is asserted.
- **Reset values:** in_ready=1, out_valid=0, sum_out=0, busy=0.
- **Captured data:** products_in changes after the accept edge do not affect the result.

## Timing

- Accept occurs at edge T (in_valid && in_ready sampled high).
- Additions occur at edges T+1 … T+N. At edge T+N the state enters DONE, so out_valid is high from T+N (9 cycles for KERNEL_SIZE=3).
- The output handshake completes at the first edge ≥ T+N where out_ready=1; the state is IDLE after that edge.
- The next accept is possible at the following edge. With out_ready tied high and in_valid held high, accepts are spaced N+2 cycles apart (11 for N=9).
- in_ready and out_valid are decoded from registered state only. They have no combinational path from in_valid or out_ready.
- With N=1, ACCUM lasts exactly one cycle.

## Test plan

- **All ones:** 9 products of 0x00000001, out_ready=1 → sum_out=0x00000009, out_valid high exactly 9 cycles after the accept edge, then one cycle of DONE.
- **Ascending values:** elements 0..8 → sum_out=36 (0x24). Also change products_in to 0xFFFFFFFF on every element one cycle after accept → result is still 36.
- **Overflow:** all elements 0xFFFFFFFF → sum_out=0xFFFFFFF7 (wrap), no X.
- **Backpressure:** out_ready low for 5 cycles after out_valid rises → sum_out and out_valid stable; in_ready stays 0 and in_valid pulses are ignored. Raise out_ready → IDLE next edge, in_ready=1.
- **Reset mid-operation:** assert rst_n=0 at cycle 4 of ACCUM → outputs immediately at reset values. Release, then send all-twos → sum_out=18 with no residue from the aborted transaction.
- **Back-to-back:** in_valid held high with sets {1×9} then {2×9}, out_ready=1 → results 9 then 18, accepts 11 cycles apart.

Source files
------------

// File: rtl/kernel_accumulator.sv
// ---------------------------------------------------------------------------
// kernel_accumulator
//
// Serial reduction stage of the convolver datapath. Accepts one packed bus of
// N = KERNEL_SIZE^2 products, captures it, then adds one element per clock
// (element 0 first) into a DATA_WIDTH accumulator. The final sum is offered
// on a valid/ready output handshake and held until it is taken.
//
// Ports
//   clk          : single clock, rising-edge active
//   rst_n        : asynchronous active-low reset
//   products_in  : N*DATA_WIDTH packed products, element i at [DW*(i+1)-1:DW*i]
//   in_valid     : products_in is valid
//   in_ready     : block is IDLE and can capture a new product set
//   sum_out      : reduced sum, modulo 2^DATA_WIDTH
//   out_valid    : sum_out is valid (state DONE)
//   out_ready    : downstream takes sum_out
//   busy         : state is not IDLE
// ---------------------------------------------------------------------------
module kernel_accumulator #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] products_in,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic [DATA_WIDTH-1:0]                      sum_out,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       busy
);

    localparam int N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int BUS_W = N * DATA_WIDTH;
    // Wide enough to count 0..N without wrapping.
    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [BUS_W-1:0]       elems_q, elems_d;
    logic [DATA_WIDTH-1:0]  acc_q,   acc_d;
    logic [IDX_W-1:0]       idx_q,   idx_d;
    logic [DATA_WIDTH-1:0]  sum_q,   sum_d;

    // Handshake and status flags decode only from the registered state.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum_out   = sum_q;

    // Next-state and datapath: capture, serial add, hold result until taken.
    always_comb begin
        state_d = state_q;
        elems_d = elems_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    elems_d = products_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                // The captured bus is shifted down one element per cycle, so
                // the lowest slice is always elem[idx]; this gives the
                // ascending summation order without a wide index mux.
                acc_d   = acc_q + elems_q[DATA_WIDTH-1:0];
                elems_d = elems_q >> DATA_WIDTH;
                idx_d   = idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_d;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            elems_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            elems_q <= elems_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_kernel_accumulator.sv
// ---------------------------------------------------------------------------
// tb_kernel_accumulator
//
// Directed bench for kernel_accumulator (DATA_WIDTH=32, KERNEL_SIZE=3).
// A table of product sets with hand-computed sums is run through the block,
// followed by backpressure, mid-operation reset and back-to-back sequences.
// ---------------------------------------------------------------------------
module tb_kernel_accumulator;

    localparam int DW = 32;
    localparam int K  = 3;
    localparam int N  = K * K;
    localparam int NW = N * DW;

    logic           clk;
    logic           rst_n;
    logic [NW-1:0]  products_in;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  sum_out;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NW-1:0] prod;
        logic [31:0]   exp_sum;
        bit            corrupt;
    } vec_t;

    vec_t vecs [5];

    kernel_accumulator #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .products_in (products_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sum_out     (sum_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [NW-1:0] fill(input logic [31:0] v);
        logic [NW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = v;
        return p;
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction with out_ready held high.
    task automatic run_txn(input logic [NW-1:0] p, input logic [31:0] exp,
                           input bit corrupt, input string tag);
        int lat;
        products_in = p;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        for (int w = 0; w < 30 && !in_ready; w++) step();
        chk({tag, "_ready_pre"}, in_ready, 32'd1);
        step();                                  // accept edge T
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 32'd1);
        chk({tag, "_inready_acc"}, in_ready, 32'd0);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1 && corrupt) products_in = fill(32'hFFFF_FFFF);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, lat, N);
        chk({tag, "_sum"}, sum_out, exp);
        chk({tag, "_inready_done"}, in_ready, 32'd0);
        step();
        chk({tag, "_ov_after"}, out_valid, 32'd0);
        chk({tag, "_ir_after"}, in_ready, 32'd1);
        chk({tag, "_busy_after"}, busy, 32'd0);
    endtask

    task automatic backpressure();
        int lat;
        logic [NW-1:0] asc;
        asc = '0;
        for (int i = 0; i < N; i++) asc[i*DW +: DW] = 32'(i);
        out_ready   = 1'b0;
        products_in = asc;
        in_valid    = 1'b1;
        for (int w = 0; w < 30 && !in_ready; w++) step();
        step();
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        chk("bp_latency", lat, N);
        for (int k = 0; k < 5; k++) begin
            in_valid    = (k % 2 == 0);
            products_in = fill(32'h0000_0007);
            step();
            chk("bp_ov_hold", out_valid, 32'd1);
            chk("bp_sum_hold", sum_out, 32'd36);
            chk("bp_ir_low", in_ready, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_ov_drop", out_valid, 32'd0);
        chk("bp_ir_rise", in_ready, 32'd1);
    endtask

    task automatic reset_mid();
        products_in = fill(32'h0000_0005);
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        for (int w = 0; w < 30 && !in_ready; w++) step();
        step();                                  // accept edge T
        in_valid = 1'b0;
        step();
        step();
        step();                                  // now in 4th ACCUM cycle
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ir", in_ready, 32'd1);
        chk("rst_mid_ov", out_valid, 32'd0);
        chk("rst_mid_busy", busy, 32'd0);
        chk("rst_mid_sum", sum_out, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_txn(fill(32'h0000_0002), 32'd18, 1'b0, "after_rst");
    endtask

    task automatic back_to_back();
        int acc_t [2];
        logic [31:0] res [2];
        int nacc;
        int nres;
        int cyc;
        bit pend;
        acc_t[0] = 0; acc_t[1] = 0;
        res[0] = '0;  res[1] = '0;
        nacc = 0; nres = 0; cyc = 0;
        out_ready   = 1'b1;
        products_in = fill(32'h0000_0001);
        in_valid    = 1'b1;
        for (int c = 0; c < 60 && nres < 2; c++) begin
            pend = in_ready && in_valid;
            step();
            cyc++;
            if (pend) begin
                if (nacc < 2) acc_t[nacc] = cyc;
                nacc++;
                if (nacc == 1) products_in = fill(32'h0000_0002);
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (nres < 2) res[nres] = sum_out;
                nres++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_naccepts", nacc, 32'd2);
        chk("b2b_nresults", nres, 32'd2);
        chk("b2b_res0", res[0], 32'd9);
        chk("b2b_res1", res[1], 32'd18);
        chk("b2b_spacing", acc_t[1] - acc_t[0], 32'd11);
    endtask

    initial begin
        logic [NW-1:0] p;

        // All ones -> 9
        vecs[0].prod = fill(32'h0000_0001); vecs[0].exp_sum = 32'h0000_0009; vecs[0].corrupt = 1'b0;
        // Ascending 0..8 -> 36, input bus corrupted after accept
        p = '0;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = 32'(i);
        vecs[1].prod = p;                   vecs[1].exp_sum = 32'h0000_0024; vecs[1].corrupt = 1'b1;
        // All 0xFFFFFFFF -> 9 * (2^32-1) mod 2^32 = 0xFFFFFFF7
        vecs[2].prod = fill(32'hFFFF_FFFF); vecs[2].exp_sum = 32'hFFFF_FFF7; vecs[2].corrupt = 1'b0;
        // 0x80000000 + 0x80000000 wraps to 0, plus 0x12345678 in element 8
        p = '0;
        p[0*DW +: DW] = 32'h8000_0000;
        p[1*DW +: DW] = 32'h8000_0000;
        p[8*DW +: DW] = 32'h1234_5678;
        vecs[3].prod = p;                   vecs[3].exp_sum = 32'h1234_5678; vecs[3].corrupt = 1'b0;
        // Powers of two 1<<i -> 0x1FF (every element position contributes)
        p = '0;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = 32'(1) << i;
        vecs[4].prod = p;                   vecs[4].exp_sum = 32'h0000_01FF; vecs[4].corrupt = 1'b0;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        products_in = '0;
        #1;
        chk("reset_ir", in_ready, 32'd1);
        chk("reset_ov", out_valid, 32'd0);
        chk("reset_sum", sum_out, 32'd0);
        chk("reset_busy", busy, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].prod, vecs[v].exp_sum, vecs[v].corrupt, $sformatf("vec%0d", v));
        end

        backpressure();
        reset_mid();
        back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
